// File: rtl/rot_seq_pkg.sv
// Shared definitions for the rotate sequencer.
//   - state_e   : FSM state encoding (IDLE, LOAD, ROTATE, DONE)
//   - DIR_*     : direction encoding carried by cmd_dir
//   - HOLD/LEFT/RIGHT : enable codes driven into rot_datapath
package rot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_ROTATE = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;

endpackage

// File: rtl/rot_datapath.sv
// WIDTH-bit rotate register used by rot_sequencer.
// Ports:
//   clk     : rising-edge clock
//   i_rst   : asynchronous active-high reset, clears the register
//   i_load  : load i_data (takes priority over i_en)
//   i_data  : word to load
//   i_en    : 00/11 hold, 01 rotate left by one, 10 rotate right by one
//   o_data  : current register contents
module rot_datapath
  import rot_seq_pkg::*;
#(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_en,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // Data register: load, single-bit rotate or hold.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else begin
      case (i_en)
        // left: bit i -> bit i+1, MSB wraps to bit 0
        LEFT:    r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        // right: bit i -> bit i-1, bit 0 wraps to MSB
        RIGHT:   r_data <= {r_data[0], r_data[WIDTH-1:1]};
        default: r_data <= r_data;
      endcase
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/rot_sequencer.sv
// Multi-cycle word rotator: accepts a command, rotates the word one bit per
// cycle in the requested direction, and presents the result until consumed.
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_dir               : 1 = rotate left, 0 = rotate right
//   cmd_amt               : rotate amount (values >= WIDTH wrap once)
//   cmd_data              : word to rotate
//   rsp_valid/rsp_ready   : result handshake (valid only in DONE)
//   rsp_data              : rotated word, stable while rsp_valid
//   busy                  : high in every state except IDLE
// Build option: define ROT_SEQ_SHORTPATH_EN to rotate the shorter way round
// when the effective amount exceeds WIDTH/2 (same result, fewer cycles).
module rot_sequencer
  import rot_seq_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int AMT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [31:0] C_WIDTH = 32'(WIDTH);

  state_e           r_state;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;

  logic             w_accept;
  logic [AMT_W-1:0] w_amt_eff;
  logic [AMT_W-1:0] w_steps;
  logic             w_dir;
  logic [1:0]       w_en;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);

  // Effective amount: one conditional subtraction of WIDTH.
  always_comb begin
    w_amt_eff = cmd_amt;
    if (32'(cmd_amt) >= C_WIDTH) begin
      w_amt_eff = AMT_W'(32'(cmd_amt) - C_WIDTH);
    end else begin
      w_amt_eff = cmd_amt;
    end
  end

`ifdef ROT_SEQ_SHORTPATH_EN
  // Rotating one way by k equals rotating the other way by WIDTH-k.
  always_comb begin
    w_dir   = cmd_dir;
    w_steps = w_amt_eff;
    if (32'(w_amt_eff) > (C_WIDTH / 32'd2)) begin
      w_dir   = ~cmd_dir;
      w_steps = AMT_W'(C_WIDTH - 32'(w_amt_eff));
    end else begin
      w_dir   = cmd_dir;
      w_steps = w_amt_eff;
    end
  end
`else
  // Always rotate the requested way for the full effective amount.
  always_comb begin
    w_dir   = cmd_dir;
    w_steps = w_amt_eff;
  end
`endif

  // Sequencer FSM and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_RIGHT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_LOAD;
            r_cnt   <= w_steps;
            r_dir   <= w_dir;
          end
        end
        ST_LOAD: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          r_cnt <= r_cnt - AMT_W'(1);
          // leave on the step that takes the counter to zero
          if (r_cnt <= AMT_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Datapath enable: rotate only while in ROTATE.
  always_comb begin
    w_en = HOLD;
    if (r_state == ST_ROTATE) begin
      w_en = (r_dir == DIR_LEFT) ? LEFT : RIGHT;
    end else begin
      w_en = HOLD;
    end
  end

  rot_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .i_rst  (reset),
    .i_load (w_accept),
    .i_data (cmd_data),
    .i_en   (w_en),
    .o_data (rsp_data)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rot_sequencer.sv
// Directed self-checking bench for rot_sequencer (WIDTH=100, AMT_W=7).
// Latency is counted in clock edges including the accept edge.
module tb_rot_sequencer;

  localparam int WIDTH = 100;
  localparam int AMT_W = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] held;

  rot_sequencer #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic send_cmd(input logic dir, input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_amt   = amt;
    cmd_data  = data;
    #1;
    chk_bit("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge (edge count 1).
  task automatic wait_rsp(input string tag, input logic [WIDTH-1:0] exp_data, input int exp_lat);
    int cycles;
    cycles = 1;
    while (!rsp_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    chk_bit({tag, "_valid"}, rsp_valid, 1'b1);
    chk_int({tag, "_latency"}, cycles, exp_lat);
    chk_vec({tag, "_data"}, rsp_data, exp_data);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_bit({tag, "_valid_drop"}, rsp_valid, 1'b0);
    chk_bit({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  initial begin
    one       = 100'd1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_amt   = 7'd0;
    cmd_data  = 100'd0;
    rsp_ready = 1'b0;
    #1;
    chk_vec("rst_data", rsp_data, 100'd0);
    chk_bit("rst_valid", rsp_valid, 1'b0);
    chk_bit("rst_ready", cmd_ready, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // left by 1
    send_cmd(1'b1, 7'd1, 100'd1);
    chk_bit("busy_load", busy, 1'b1);
    wait_rsp("left1", 100'd2, 3);
    consume("left1");

    // right by 4: bit 0 wraps to bit 96
    send_cmd(1'b0, 7'd4, 100'd1);
    wait_rsp("right4", one << 96, 6);
    consume("right4");

    // amount 0 and amount WIDTH both leave the word unchanged
    send_cmd(1'b1, 7'd0, 100'hA5);
    wait_rsp("amt0", 100'hA5, 2);
    consume("amt0");
    send_cmd(1'b1, 7'd100, 100'hA5);
    wait_rsp("amt100", 100'hA5, 2);
    consume("amt100");

    // amount 101 wraps to 1; right by 1 of 0xA5
    send_cmd(1'b0, 7'd101, 100'hA5);
    wait_rsp("right101", (one << 99) | 100'h52, 3);
    consume("right101");

    // amount 127 wraps to 27
    send_cmd(1'b1, 7'd127, 100'd1);
    wait_rsp("left127", one << 27, 29);
    consume("left127");

    // left by 99 and by 60: shorter path when enabled
`ifdef ROT_SEQ_SHORTPATH_EN
    send_cmd(1'b1, 7'd99, 100'd1);
    wait_rsp("left99", one << 99, 3);
    consume("left99");
    send_cmd(1'b1, 7'd60, 100'd1);
    wait_rsp("left60", one << 60, 42);
    consume("left60");
`else
    send_cmd(1'b1, 7'd99, 100'd1);
    wait_rsp("left99", one << 99, 101);
    consume("left99");
    send_cmd(1'b1, 7'd60, 100'd1);
    wait_rsp("left60", one << 60, 62);
    consume("left60");
`endif

    // backpressure in DONE with a competing command offered
    send_cmd(1'b1, 7'd3, 100'h5);
    wait_rsp("bp", 100'h28, 5);
    held      = 100'h28;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_amt   = 7'd0;
    cmd_data  = 100'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_vec("bp_hold_data", rsp_data, held);
      chk_bit("bp_hold_valid", rsp_valid, 1'b1);
      chk_bit("bp_no_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_bit("bp_not_taken_busy", busy, 1'b0);
    chk_bit("bp_idle_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("bp_second", 100'h77, 2);
    consume("bp_second");

    // asynchronous reset in the middle of a long rotate
    send_cmd(1'b1, 7'd50, 100'd1);
    repeat (3) @(negedge clk);
    chk_bit("mid_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("arst_busy", busy, 1'b0);
    chk_bit("arst_valid", rsp_valid, 1'b0);
    chk_vec("arst_data", rsp_data, 100'd0);
    chk_bit("arst_ready", cmd_ready, 1'b1);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_amt   = 7'd1;
    cmd_data  = 100'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("post_rst", 100'd2, 3);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
